enemy_kill_sequencer: RTL and testbench
=======================================

Name: enemy_kill_sequencer

Overview:
- Downstream consumer of the enemy hit flag; owns everything after a laser-to-enemy hit is detected.
- On a hit it captures the enemy position, adds points to a BCD score and plays a frame-timed explosion animation.
- It then hides the enemy for a respawn delay and pulses done, which clears the sticky hit flag in the hit detector.
- Outputs feed the sprite renderer (explosion, enemy visibility) and the score display.

Parameters:
- EXPL_FRAMES, 4: number of explosion animation frames, 1..4.
- FRAME_HOLD, 6: frame ticks each animation frame is shown, ≥1.
- RESPAWN_DELAY, 30: frame ticks enemy stays hidden after the explosion, ≥1.
- POINTS_BCD, 16'h0010: BCD points per kill, 4 digits.

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Reset  in  1  asynchronous, active-low reset (asserted at 0).
- frame_clk  in  1  vsync-rate level signal, not a clock; sampled in Clk domain.
- enemy_hit  in  1  sticky hit flag from the hit detector.
- enemy_ship_X_Pos  in  10  current enemy X.
- enemy_ship_Y_Pos  in  10  current enemy Y.
- done  out  1  one-Clk pulse ending the kill sequence; clears enemy_hit upstream.
- enemy_visible  out  1  1 = draw enemy.
- expl_active  out  1  1 = draw explosion.
- expl_frame  out  2  current explosion animation index.
- expl_X_Pos  out  10  latched explosion X.
- expl_Y_Pos  out  10  latched explosion Y.
- score_bcd  out  16  4-digit BCD score.
- kill_count  out  8  binary kill counter.

Behaviour:
- Reset (Reset=0, async) clears all state and outputs: state=IDLE, done=0, enemy_visible=1, expl_active=0, expl_frame=0, expl_X_Pos=0, expl_Y_Pos=0, score_bcd=0, kill_count=0, all counters 0.
- Releasing Reset mid-sequence always restarts from IDLE.
- frame_clk passes through a 2-flop synchronizer, then a rising-edge detector producing tick.
- tick is a 1-Clk pulse, 3 Clk cycles after frame_clk rises. All frame timing counts ticks only.
- All outputs are registered.
- FSM states: IDLE, LATCH, EXPLODE, RESPAWN, DONE.
- IDLE:
  - enemy_visible=1, expl_active=0.
  - enemy_hit=1 sampled → LATCH next cycle.
- LATCH (exactly 1 cycle):
  - expl_X/Y_Pos capture enemy_ship_X/Y_Pos.
  - score_bcd += POINTS_BCD (BCD digit-wise carry), saturating at 16'h9999.
  - kill_count += 1, wrapping 255→0.
  - Clear hold_cnt and frame_cnt → EXPLODE.
- EXPLODE:
  - expl_active=1, enemy_visible=0.
  - On tick: hold_cnt increments. At hold_cnt==FRAME_HOLD-1, hold_cnt→0 and expl_frame increments.
  - A tick with expl_frame==EXPL_FRAMES-1 and hold_cnt==FRAME_HOLD-1 → RESPAWN, expl_active=0, expl_frame=0.
  - Duration is exactly EXPL_FRAMES*FRAME_HOLD ticks.
- RESPAWN:
  - enemy_visible=0, expl_active=0.
  - Count RESPAWN_DELAY ticks. The tick that completes the count → DONE.
- DONE (exactly 1 cycle):
  - done=1, enemy_visible=1 → IDLE.
  - done is high for exactly one Clk cycle per kill, never otherwise.
- enemy_hit is ignored in LATCH, EXPLODE, RESPAWN and DONE. No re-trigger and no double scoring.
- A tick coinciding with the LATCH cycle is not counted.
- A tick arriving in the same cycle as the IDLE→LATCH transition is lost. This is accepted.
- Score saturation: 16'h9990 + 16'h0010 → 16'h9999 (not 16'h0000).

Optional Feature:
- Macro: COMBO_BONUS_EN.
- When defined:
  - A 6-bit counter combo_cnt resets to 0 in DONE and increments on each tick in IDLE, saturating at 63.
  - In LATCH, if a previous kill exists and combo_cnt < 20, points added = 2×POINTS_BCD (BCD add of POINTS_BCD twice in one cycle), saturating at 16'h9999.
  - The first kill after reset never earns the bonus.
- When undefined: no combo logic is synthesized and points are always POINTS_BCD.

Test Plan:
- Reset behaviour: hold Reset=0, toggle frame_clk → enemy_visible=1, all other outputs 0. Release Reset → still IDLE; no done without enemy_hit.
- Single kill (EXPL_FRAMES=4, FRAME_HOLD=2, RESPAWN_DELAY=3), enemy at (100,200), assert enemy_hit:
  - LATCH 1 cycle later; expl_X/Y=100/200; score_bcd=16'h0010; kill_count=1.
  - expl_frame steps 0,1,2,3 every 2 ticks; expl_active falls after 8 ticks.
  - done pulses 1 cycle after the 3rd RESPAWN tick. Model enemy_hit clearing on done → returns to IDLE.
- Hit held high: keep enemy_hit=1 throughout the sequence → exactly one score increment. A second kill starts only when enemy_hit is re-asserted after done.
- Saturation: preload to 16'h9990 via 999 kills (or a forced start value), then one kill → score_bcd=16'h9999; next kill → stays 16'h9999. kill_count wraps 255→0 on the 256th kill.
- Reset mid-EXPLODE: assert Reset=0 at expl_frame=2 → outputs return to reset values immediately (async). done is never asserted.
- COMBO_BONUS_EN: two kills with 5 ticks of IDLE between them → score 16'h0010 then 16'h0030. Gap of 25 ticks → 16'h0020. Without the macro, both cases give 16'h0020.

Source files
------------

// File: rtl/enemy_kill_sequencer.sv
// Kill sequence after a laser hit: latch position, score, explosion animation, respawn delay, done pulse.
// Optional `COMBO_BONUS_EN: double points for a kill within 20 idle frame ticks of the previous one.
module enemy_kill_sequencer #(
   parameter int unsigned EXPL_FRAMES   = 4,
   parameter int unsigned FRAME_HOLD    = 6,
   parameter int unsigned RESPAWN_DELAY = 30,
   parameter logic [15:0] POINTS_BCD    = 16'h0010
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic        enemy_hit,
   input  logic [9:0]  enemy_ship_X_Pos,
   input  logic [9:0]  enemy_ship_Y_Pos,
   output logic        done,
   output logic        enemy_visible,
   output logic        expl_active,
   output logic [1:0]  expl_frame,
   output logic [9:0]  expl_X_Pos,
   output logic [9:0]  expl_Y_Pos,
   output logic [15:0] score_bcd,
   output logic [7:0]  kill_count
);

   typedef enum logic [2:0] {S_IDLE, S_LATCH, S_EXPLODE, S_RESPAWN, S_DONE} state_e;

   localparam logic [15:0] HOLD_LAST  = 16'(FRAME_HOLD - 1);
   localparam logic [1:0]  FRAME_LAST = 2'(EXPL_FRAMES - 1);
   localparam logic [15:0] RESP_LAST  = 16'(RESPAWN_DELAY - 1);

   state_e       state_q, state_d;
   logic [2:0]   fc_q;
   logic         tick_q;
   logic [15:0]  hold_q, hold_d;
   logic [1:0]   frame_q, frame_d;
   logic [15:0]  resp_q, resp_d;
   logic [9:0]   xpos_q, xpos_d, ypos_q, ypos_d;
   logic [15:0]  score_q, score_d;
   logic [7:0]   kills_q, kills_d;
   logic         done_q, done_d;
   logic         vis_q, vis_d;
   logic         act_q, act_d;
`ifdef COMBO_BONUS_EN
   logic [5:0]   combo_q, combo_d;
   logic         prev_kill_q, prev_kill_d;
`endif

   // Digit-wise BCD add; a carry out of the top digit saturates to 9999.
   function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [15:0] b);
      logic [4:0]  s;
      logic        c;
      logic [15:0] r;
      c = 1'b0;
      r = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
         if (s > 5'd9) begin
            s = s - 5'd10;
            c = 1'b1;
         end else begin
            c = 1'b0;
         end
         r[4*i +: 4] = s[3:0];
      end
      return c ? 16'h9999 : r;
   endfunction

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q     <= S_IDLE;
         fc_q        <= '0;
         tick_q      <= 1'b0;
         hold_q      <= '0;
         frame_q     <= '0;
         resp_q      <= '0;
         xpos_q      <= '0;
         ypos_q      <= '0;
         score_q     <= '0;
         kills_q     <= '0;
         done_q      <= 1'b0;
         vis_q       <= 1'b1;
         act_q       <= 1'b0;
`ifdef COMBO_BONUS_EN
         combo_q     <= '0;
         prev_kill_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         fc_q        <= {fc_q[1:0], frame_clk};
         tick_q      <= fc_q[1] & ~fc_q[2];
         hold_q      <= hold_d;
         frame_q     <= frame_d;
         resp_q      <= resp_d;
         xpos_q      <= xpos_d;
         ypos_q      <= ypos_d;
         score_q     <= score_d;
         kills_q     <= kills_d;
         done_q      <= done_d;
         vis_q       <= vis_d;
         act_q       <= act_d;
`ifdef COMBO_BONUS_EN
         combo_q     <= combo_d;
         prev_kill_q <= prev_kill_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      frame_d = frame_q;
      resp_d  = resp_q;
      xpos_d  = xpos_q;
      ypos_d  = ypos_q;
      score_d = score_q;
      kills_d = kills_q;
`ifdef COMBO_BONUS_EN
      combo_d     = combo_q;
      prev_kill_d = prev_kill_q;
`endif
      case (state_q)
         S_IDLE: begin
`ifdef COMBO_BONUS_EN
            if (tick_q && combo_q != 6'd63) combo_d = combo_q + 6'd1;
`endif
            if (enemy_hit) state_d = S_LATCH;
         end
         S_LATCH: begin
            xpos_d  = enemy_ship_X_Pos;
            ypos_d  = enemy_ship_Y_Pos;
            score_d = bcd_add_sat(score_q, POINTS_BCD);
`ifdef COMBO_BONUS_EN
            if (prev_kill_q && combo_q < 6'd20) score_d = bcd_add_sat(score_d, POINTS_BCD);
            prev_kill_d = 1'b1;
`endif
            kills_d = kills_q + 8'd1;
            hold_d  = '0;
            frame_d = '0;
            resp_d  = '0;
            state_d = S_EXPLODE;
         end
         S_EXPLODE: begin
            if (tick_q) begin
               if (hold_q == HOLD_LAST) begin
                  hold_d = '0;
                  if (frame_q == FRAME_LAST) begin
                     frame_d = '0;
                     state_d = S_RESPAWN;
                  end else begin
                     frame_d = frame_q + 2'd1;
                  end
               end else begin
                  hold_d = hold_q + 16'd1;
               end
            end
         end
         S_RESPAWN: begin
            if (tick_q) begin
               if (resp_q == RESP_LAST) begin
                  resp_d  = '0;
                  state_d = S_DONE;
               end else begin
                  resp_d = resp_q + 16'd1;
               end
            end
         end
         S_DONE: begin
`ifdef COMBO_BONUS_EN
            combo_d = '0;
`endif
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Flag outputs are decoded from the next state so their registers line up with state_q.
   always_comb begin
      done_d = (state_d == S_DONE);
      vis_d  = (state_d == S_IDLE) || (state_d == S_LATCH) || (state_d == S_DONE);
      act_d  = (state_d == S_EXPLODE);
   end

   assign done          = done_q;
   assign enemy_visible = vis_q;
   assign expl_active   = act_q;
   assign expl_frame    = frame_q;
   assign expl_X_Pos    = xpos_q;
   assign expl_Y_Pos    = ypos_q;
   assign score_bcd     = score_q;
   assign kill_count    = kills_q;

endmodule

// File: tb/tb_enemy_kill_sequencer.sv
// Scoreboard bench for enemy_kill_sequencer: random kills, frame timing, saturation, mid-sequence reset.
module tb_enemy_kill_sequencer;
   localparam int unsigned EF = 4;
   localparam int unsigned FH = 2;
   localparam int unsigned RD = 3;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        frame_clk = 1'b0;
   logic        enemy_hit = 1'b0;
   logic [9:0]  ex = '0, ey = '0;
   logic        done, enemy_visible, expl_active;
   logic [1:0]  expl_frame;
   logic [9:0]  expl_X_Pos, expl_Y_Pos;
   logic [15:0] score_bcd;
   logic [7:0]  kill_count;

   enemy_kill_sequencer #(
      .EXPL_FRAMES(EF), .FRAME_HOLD(FH), .RESPAWN_DELAY(RD), .POINTS_BCD(16'h0010)
   ) dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .enemy_hit(enemy_hit),
      .enemy_ship_X_Pos(ex), .enemy_ship_Y_Pos(ey),
      .done(done), .enemy_visible(enemy_visible), .expl_active(expl_active),
      .expl_frame(expl_frame), .expl_X_Pos(expl_X_Pos), .expl_Y_Pos(expl_Y_Pos),
      .score_bcd(score_bcd), .kill_count(kill_count)
   );

   typedef struct {
      int unsigned x, y, score, kc;
   } exp_t;

   int unsigned n_checks = 0, n_fail = 0;
   int unsigned cyc = 0;
   bit          tick_at[int unsigned];
   bit          fast = 1'b0;
   exp_t        exp_q[$];

   int unsigned ref_score = 0, ref_kills = 0, last_done = 0;
   bit          ref_prev = 1'b0;

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string name, input int unsigned act, input int unsigned want);
      n_checks++;
      if (act != want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   function automatic int unsigned to_bcd(input int unsigned v);
      return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
   endfunction

`ifdef COMBO_BONUS_EN
   function automatic int unsigned count_ticks(input int unsigned lo, input int unsigned hi);
      int unsigned n = 0;
      for (int unsigned c = lo + 1; c <= hi; c++) if (tick_at.exists(c)) n++;
      return n;
   endfunction
`endif

   // Frame "clock": each rise yields a tick three Clk cycles later.
   initial begin
      forever begin
         repeat (fast ? 1 : $urandom_range(2, 6)) @(posedge Clk);
         #1 frame_clk = 1'b1;
         tick_at[cyc + 3] = 1'b1;
         repeat (fast ? 1 : $urandom_range(2, 6)) @(posedge Clk);
         #1 frame_clk = 1'b0;
      end
   end

   // Monitor: pops expectations when an explosion starts, checks animation and respawn timing.
   exp_t        cur;
   bit          in_kill = 1'b0, p_active = 1'b0;
   int unsigned ext = 0, rt = 0, last_rt = 0, done_cnt = 0;
   always @(negedge Clk) begin
      if (!Reset) begin
         in_kill  = 1'b0;
         p_active = 1'b0;
      end else begin
         if (expl_active && !p_active) begin
            if (exp_q.size() == 0) begin
               check("unexpected_kill", 1, 0);
            end else begin
               cur = exp_q.pop_front();
               check("expl_x", 32'(expl_X_Pos), cur.x);
               check("expl_y", 32'(expl_Y_Pos), cur.y);
               check("score", 32'(score_bcd), cur.score);
               check("kill_count", 32'(kill_count), cur.kc);
               in_kill = 1'b1;
               ext = 0;
               rt = 0;
            end
         end
         if (expl_active) check("hidden_in_explode", 32'(enemy_visible), 0);
         if (tick_at.exists(cyc) && expl_active) begin
            check("expl_frame", 32'(expl_frame), ext / FH);
            ext++;
         end
         if (!expl_active && p_active) begin
            check("explode_ticks", ext, EF * FH);
            check("frame_cleared", 32'(expl_frame), 0);
         end
         if (tick_at.exists(cyc) && in_kill && !expl_active && !enemy_visible) begin
            rt++;
            last_rt = cyc;
         end
         if (done) begin
            done_cnt++;
            if (!in_kill) begin
               check("stray_done", 1, 0);
            end else begin
               check("respawn_ticks", rt, RD);
               check("done_timing", cyc, last_rt + 1);
               check("visible_at_done", 32'(enemy_visible), 1);
               check("score_held", 32'(score_bcd), cur.score);
               check("x_held", 32'(expl_X_Pos), cur.x);
            end
            in_kill = 1'b0;
         end
         p_active = expl_active;
      end
   end

   task automatic ref_kill(input int unsigned h, input logic [9:0] x, input logic [9:0] y);
      int unsigned pts;
      pts = 10;
`ifdef COMBO_BONUS_EN
      if (ref_prev && count_ticks(last_done, h) < 20) pts = 20;
`endif
      ref_score = (ref_score + pts > 9999) ? 9999 : ref_score + pts;
      ref_kills = (ref_kills + 1) % 256;
      ref_prev  = 1'b1;
      exp_q.push_back('{x: 32'(x), y: 32'(y), score: to_bcd(ref_score), kc: ref_kills});
   endtask

   task automatic issue_kill(input int unsigned gap, input logic [9:0] x, input logic [9:0] y,
                             input bit chaos);
      int unsigned h;
      bit seen;
      repeat (gap) @(posedge Clk);
      @(posedge Clk);
      #1;
      h = cyc;
      ref_kill(h, x, y);
      ex = x;
      ey = y;
      enemy_hit = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge Clk);
         if (expl_active) begin
            seen = 1'b1;
            break;
         end
      end
      check("latch_latency", seen ? cyc - h : 0, 2);
      ex = 10'($urandom);
      ey = 10'($urandom);
      seen = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge Clk);
         #1;
         if (chaos) enemy_hit = 1'($urandom);
         @(negedge Clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check("done_seen", 32'(seen), 1);
      last_done = cyc;
      @(posedge Clk);
      #1 enemy_hit = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_visible"}, 32'(enemy_visible), 1);
      check({tag, "_active"}, 32'(expl_active), 0);
      check({tag, "_frame"}, 32'(expl_frame), 0);
      check({tag, "_x"}, 32'(expl_X_Pos), 0);
      check({tag, "_y"}, 32'(expl_Y_Pos), 0);
      check({tag, "_score"}, 32'(score_bcd), 0);
      check({tag, "_kills"}, 32'(kill_count), 0);
   endtask

   initial begin
      int unsigned d0, guard;
      bit seen;

      repeat (12) @(negedge Clk);
      check_reset_values("por");
      #2 Reset = 1'b1;
      repeat (25) @(negedge Clk);
      check("idle_no_done", done_cnt, 0);
      check("idle_visible", 32'(enemy_visible), 1);

      issue_kill(0, 10'd100, 10'd200, 1'b0);
      issue_kill(3, 10'd5, 10'd1023, 1'b1);

      // Abort a kill in the middle of its explosion.
      @(posedge Clk);
      #1;
      ref_kill(cyc, 10'd321, 10'd123);
      ex = 10'd321;
      ey = 10'd123;
      enemy_hit = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge Clk);
         if (expl_frame == 2'd2) begin
            seen = 1'b1;
            break;
         end
      end
      check("reached_frame2", 32'(seen), 1);
      #2 Reset = 1'b0;
      #1 check_reset_values("async");
      enemy_hit = 1'b0;
      ref_score = 0;
      ref_kills = 0;
      ref_prev  = 1'b0;
      exp_q.delete();
      d0 = done_cnt;
      repeat (5) @(negedge Clk);
      #2 Reset = 1'b1;
      repeat (60) @(negedge Clk);
      check("no_done_after_abort", done_cnt, d0);

      for (int k = 0; k < 20; k++)
         issue_kill($urandom_range(0, 150), 10'($urandom), 10'($urandom), 1'($urandom));

      fast  = 1'b1;
      guard = 0;
      while (ref_score < 9990 && guard < 1200) begin
         issue_kill(0, 10'($urandom), 10'($urandom), 1'b0);
         guard++;
      end
      issue_kill(0, 10'($urandom), 10'($urandom), 1'b0);
      issue_kill(1, 10'($urandom), 10'($urandom), 1'b0);
      check("saturated_score", 32'(score_bcd), 32'h9999);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #950000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end
endmodule
